// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART boot loader: frames a byte stream into memory writes, holds core in reset until done
// Optional payload checksum byte: define BOOT_CHECKSUM_EN.
module uart_boot_loader #(
  parameter int unsigned MEMORY_SIZE    = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 25000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rst_n,
  output logic        boot_done,
  output logic        boot_error
);

  localparam int unsigned MAX_WORDS = MEMORY_SIZE / 4;

  typedef enum logic [2:0] {
    S_WAIT_SYNC,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef BOOT_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  // State entered once the payload (or an empty frame) has been consumed.
`ifdef BOOT_CHECKSUM_EN
  localparam state_t END_STATE = S_CHECK;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t      state_q, state_n;
  logic [7:0]  len_lo_q, len_lo_n;
  logic [15:0] len_q, len_n;
  logic [15:0] word_q, word_n;
  logic [1:0]  bcnt_q, bcnt_n;
  logic [31:0] asm_q, asm_n;
  logic [31:0] tmo_q, tmo_n;
  logic        mem_we_n;
  logic [31:0] mem_addr_n, mem_wdata_n;
  logic        tmo_hit;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum_q, csum_n;
`endif

  assign tmo_hit = (tmo_q == TIMEOUT_CYCLES - 1);

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAIT_SYNC;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_q     <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      tmo_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst_n <= 1'b0;
      boot_done  <= 1'b0;
      boot_error <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_n;
      len_lo_q   <= len_lo_n;
      len_q      <= len_n;
      word_q     <= word_n;
      bcnt_q     <= bcnt_n;
      asm_q      <= asm_n;
      tmo_q      <= tmo_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      core_rst_n <= (state_n == S_DONE);
      boot_done  <= (state_n == S_DONE);
      boot_error <= (state_n == S_ERROR);
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= csum_n;
`endif
    end
  end

  // Frame parser: next state, counters and write request. Timeout always beats rx_valid.
  always_comb begin
    state_n     = state_q;
    len_lo_n    = len_lo_q;
    len_n       = len_q;
    word_n      = word_q;
    bcnt_n      = bcnt_q;
    asm_n       = asm_q;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    // Inside a frame the counter measures the gap since the last byte.
    tmo_n       = rx_valid ? 32'd0 : tmo_q + 32'd1;
`ifdef BOOT_CHECKSUM_EN
    csum_n      = csum_q;
`endif
    case (state_q)
      S_WAIT_SYNC: begin
        // Non-sync bytes do not extend the boot window.
        tmo_n = tmo_q + 32'd1;
        if (tmo_hit) begin
          state_n = S_DONE;
        end else if (rx_valid && rx_data == SYNC_BYTE) begin
          state_n = S_LEN_LO;
          tmo_n   = '0;
        end
      end
      S_LEN_LO: begin
        if (tmo_hit) begin
          state_n = S_ERROR;
        end else if (rx_valid) begin
          len_lo_n = rx_data;
          state_n  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (tmo_hit) begin
          state_n = S_ERROR;
        end else if (rx_valid) begin
          len_n  = {rx_data, len_lo_q};
          word_n = '0;
          bcnt_n = '0;
`ifdef BOOT_CHECKSUM_EN
          csum_n = '0;
`endif
          if (len_n == 16'd0) begin
            state_n = END_STATE;
          end else if ({16'd0, len_n} > MAX_WORDS) begin
            state_n = S_ERROR;
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        // Release only after the final write strobe has been presented.
        if (mem_we && word_q == len_q) begin
          state_n = END_STATE;
        end else if (tmo_hit) begin
          state_n = S_ERROR;
        end else if (rx_valid) begin
          asm_n  = {rx_data, asm_q[31:8]};
          bcnt_n = bcnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_n = csum_q ^ rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            mem_we_n    = 1'b1;
            mem_addr_n  = {14'd0, word_q, 2'b00};
            mem_wdata_n = asm_n;
            word_n      = word_q + 16'd1;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHECK: begin
        if (tmo_hit) begin
          state_n = S_ERROR;
        end else if (rx_valid) begin
          state_n = (rx_data == csum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: begin
        // DONE and ERROR are terminal; application traffic is ignored.
        tmo_n = tmo_q;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - directed self-checking bench for uart_boot_loader
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst_n;
  logic        boot_done;
  logic        boot_error;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  txq[$];
  logic [31:0] wr_addr[16];
  logic [31:0] wr_data[16];
  int          wr_cyc[16];
  int          wr_cnt = 0;
  int          cyc = 0;
  int          rel_cyc = -1;

  uart_boot_loader #(
    .MEMORY_SIZE(4096),
    .TIMEOUT_CYCLES(100),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n),
    .boot_done(boot_done),
    .boot_error(boot_error)
  );

  always #5 clk = ~clk;

  // Log write strobes and the first cycle the core is released.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc = cyc + 1;
      if (mem_we && wr_cnt < 16) begin
        wr_addr[wr_cnt] = mem_addr;
        wr_data[wr_cnt] = mem_wdata;
        wr_cyc[wr_cnt]  = cyc;
        wr_cnt = wr_cnt + 1;
      end
      if (core_rst_n && rel_cyc < 0) rel_cyc = cyc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    wr_cnt = 0;
    cyc = 0;
    rel_cyc = -1;
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_q(input int gap);
    while (txq.size() > 0) begin
      rx_valid = 1'b1;
      rx_data  = txq.pop_front();
      @(negedge clk);
      if (gap > 0) begin
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_csum(input logic [7:0] c);
`ifdef BOOT_CHECKSUM_EN
    repeat (2) @(negedge clk);
    txq.push_back(c);
    send_q(2);
`else
    if (c === 8'hxx) rx_data = 8'h00;
`endif
  endtask

  task automatic check_outputs_zero(input string tag);
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata, core_rst_n, boot_done, boot_error} !== 68'd0) begin
      n_err++;
      $display("FAIL %s: outputs got we=%0b addr=%h data=%h crst=%0b done=%0b err=%0b expected all 0",
               tag, mem_we, mem_addr, mem_wdata, core_rst_n, boot_done, boot_error);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_state");
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_held");
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (120) @(negedge clk);
    n_cmp++;
    if (rel_cyc !== 100) begin
      n_err++; $display("FAIL timeout_cycle: got %0d expected 100", rel_cyc);
    end
    n_cmp++;
    if ({boot_done, core_rst_n, boot_error} !== 3'b110) begin
      n_err++; $display("FAIL timeout_flags: got %b expected 110", {boot_done, core_rst_n, boot_error});
    end
    n_cmp++;
    if (wr_cnt !== 0) begin
      n_err++; $display("FAIL timeout_writes: got %0d expected 0", wr_cnt);
    end
  endtask

  task automatic test_frame();
    do_reset();
    txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_q(3);
    send_csum(8'h69);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (wr_cnt !== 2) begin
      n_err++; $display("FAIL frame_write_count: got %0d expected 2", wr_cnt);
    end
    n_cmp++;
    if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00100513) begin
      n_err++; $display("FAIL frame_word0: got %h/%h expected 00000000/00100513", wr_addr[0], wr_data[0]);
    end
    n_cmp++;
    if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h0000006F) begin
      n_err++; $display("FAIL frame_word1: got %h/%h expected 00000004/0000006f", wr_addr[1], wr_data[1]);
    end
`ifndef BOOT_CHECKSUM_EN
    n_cmp++;
    if (rel_cyc !== wr_cyc[1] + 1) begin
      n_err++; $display("FAIL frame_release_cycle: got %0d expected %0d", rel_cyc, wr_cyc[1] + 1);
    end
`endif
    n_cmp++;
    if ({boot_done, core_rst_n, boot_error, mem_we} !== 4'b1100) begin
      n_err++; $display("FAIL frame_flags: got %b expected 1100", {boot_done, core_rst_n, boot_error, mem_we});
    end
    // Application traffic after DONE must not write memory.
    txq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q(1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_cnt !== 2 || boot_done !== 1'b1) begin
      n_err++; $display("FAIL done_ignores_rx: got writes=%0d done=%0b expected 2/1", wr_cnt, boot_done);
    end
  endtask

  task automatic test_garbage_zero_len();
    do_reset();
    txq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    send_q(2);
    send_csum(8'h00);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({boot_done, core_rst_n, boot_error} !== 3'b110) begin
      n_err++; $display("FAIL zero_len_flags: got %b expected 110", {boot_done, core_rst_n, boot_error});
    end
    n_cmp++;
    if (wr_cnt !== 0) begin
      n_err++; $display("FAIL zero_len_writes: got %0d expected 0", wr_cnt);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    txq = '{8'hA5, 8'h01, 8'h04};
    send_q(2);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({boot_error, core_rst_n, boot_done} !== 3'b100) begin
      n_err++; $display("FAIL oversize_flags: got %b expected 100", {boot_error, core_rst_n, boot_done});
    end
    txq = '{8'hA5, 8'h00, 8'h00};
    send_q(2);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({boot_error, core_rst_n, boot_done} !== 3'b100 || wr_cnt !== 0) begin
      n_err++; $display("FAIL error_sticky: got %b writes=%0d expected 100 writes=0",
                        {boot_error, core_rst_n, boot_done}, wr_cnt);
    end
  endtask

  task automatic test_max_len_stall();
    do_reset();
    txq = '{8'hA5, 8'h00, 8'h04};
    send_q(2);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({boot_error, boot_done} !== 2'b00) begin
      n_err++; $display("FAIL max_len_accepted: got %b expected 00", {boot_error, boot_done});
    end
    repeat (110) @(negedge clk);
    n_cmp++;
    if ({boot_error, core_rst_n, boot_done} !== 3'b100) begin
      n_err++; $display("FAIL interbyte_timeout: got %b expected 100", {boot_error, core_rst_n, boot_done});
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05};
    send_q(2);
    n_cmp++;
    if (wr_cnt !== 0) begin
      n_err++; $display("FAIL midframe_no_write: got %0d expected 0", wr_cnt);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midframe_reset");
    do_reset();
    txq = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_q(2);
    send_csum(8'h22);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_cnt !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hEFBEADDE) begin
      n_err++; $display("FAIL reload_word: got n=%0d %h/%h expected 1 00000000/efbeadde",
                        wr_cnt, wr_addr[0], wr_data[0]);
    end
    n_cmp++;
    if (boot_done !== 1'b1) begin
      n_err++; $display("FAIL reload_done: got %0b expected 1", boot_done);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    txq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_q(0);
    send_csum(8'h04);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_cnt !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h04030201) begin
      n_err++; $display("FAIL b2b_word: got n=%0d %h/%h expected 1 00000000/04030201",
                        wr_cnt, wr_addr[0], wr_data[0]);
    end
    n_cmp++;
    if ({boot_done, core_rst_n} !== 2'b11) begin
      n_err++; $display("FAIL b2b_done: got %b expected 11", {boot_done, core_rst_n});
    end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    txq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q(2);
    send_csum(8'h44);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({boot_done, boot_error} !== 2'b10) begin
      n_err++; $display("FAIL csum_good: got %b expected 10", {boot_done, boot_error});
    end
    do_reset();
    txq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q(2);
    send_csum(8'h45);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({boot_done, boot_error, core_rst_n} !== 3'b010) begin
      n_err++; $display("FAIL csum_bad: got %b expected 010", {boot_done, boot_error, core_rst_n});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_timeout();
    test_frame();
    test_garbage_zero_len();
    test_oversize();
    test_max_len_stall();
    test_reset_midframe();
    test_back_to_back();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
